pic_core_p: RTL and testbench
=============================

PIC_CORE_P -- requirements
Module: pic_core_p

Interface
REQ-001 SHALL have parameter DATA_W, default 8, datapath/W/RAM word width (legal range 8..16).
REQ-002 SHALL have parameter PC_W, default 11, program counter and ROM address width (legal range 8..11).
REQ-003 SHALL have parameter RAM_AW, default 7, data RAM address width (legal range 4..7); RAM holds 2**RAM_AW words.
REQ-004 SHALL have parameter STACK_DEPTH, default 8, number of return-address stack entries (power of two, legal range 2..16).
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port rom_addr  output  PC_W  registered instruction fetch address (MAR).
REQ-008 SHALL have port rom_data  input  14  instruction word, combinationally valid for the current rom_addr.
REQ-009 SHALL have port w_q  output  DATA_W  working register.
REQ-010 SHALL have port status_q  output  2  {C,Z} flags.
REQ-011 SHALL have port stk_ovf  output  1  sticky flag: push while stack full.
REQ-012 SHALL have port stk_unf  output  1  sticky flag: pop while stack empty.
REQ-013 SHALL have port phase_q  output  3  current controller state (T0..T6 = 0..6).

Function
REQ-014 SHALL run the state sequence T0->T1 once after reset, then T1->T2->T3->T4->T5->T6->T1, with each state lasting one cycle and each instruction taking 6 cycles.
REQ-015 SHALL, in each state, perform:
- T1: MAR<=PC.
- T2: PC<=PC+1 (mod 2**PC_W).
- T3: IR<=rom_data.
- T4: execute; write back to W, RAM, status and stack.
- T5: PC<=PC+1 if a skip is pending.
- T6: idle.
REQ-016 SHALL zero-extend the literal ir[7:0] to DATA_W; RAM address SHALL be ir[RAM_AW-1:0]; d=ir[7].
REQ-017 SHALL decode ir[13:8]:
- Literal ops: 0x30 MOVLW, 0x3E ADDLW, 0x3C SUBLW (k-W), 0x39 ANDLW, 0x38 IORLW, 0x3A XORLW.
- File ops: 0x07 ADDWF, 0x02 SUBWF (f-W), 0x05 ANDWF, 0x04 IORWF, 0x06 XORWF, 0x09 COMF, 0x0A INCF, 0x03 DECF, 0x08 MOVF, 0x0B DECFSZ, 0x0F INCFSZ.
- Clear/move: 0x01 with d=1 CLRF; 0x01 with d=0 CLRW; 0x00 with d=1 MOVWF.
REQ-018 SHALL decode control ops: ir[13:11]=101 GOTO, ir[13:11]=100 CALL, ir=0x0008 RETURN, ir[13:10]=0110 BTFSC, ir[13:10]=0111 BTFSS (bit index ir[9:7]).
REQ-019 SHALL treat every other encoding, including 0x0000, as NOP with no state change.
REQ-020 SHALL route file-op results to RAM when d=1 and to W when d=0.
REQ-021 SHALL truncate all arithmetic to DATA_W bits.
REQ-022 SHALL set C on ADD/SUB only: ADD C=carry-out; SUB C=1 when no borrow.
REQ-023 SHALL set Z=(result==0) on every ALU op except MOVLW, MOVWF, DECFSZ and INCFSZ; CLRF/CLRW SHALL set Z=1.
REQ-024 SHALL set PC<=ir[PC_W-1:0] on GOTO in T4.
REQ-025 SHALL, on CALL in T4, push the already-incremented PC and then load PC<=ir[PC_W-1:0].
REQ-026 SHALL, on RETURN in T4, pop the top of stack into PC.
REQ-027 SHALL, on DECFSZ/INCFSZ, write the result per d and set skip pending when the result==0.
REQ-028 SHALL, on BTFSC/BTFSS, set skip pending when the tested RAM bit is 0/1 respectively.
REQ-029 SHALL never fetch a skipped instruction and SHALL add no extra cycles for a skip.
REQ-030 SHALL implement the stack as circular:
- Push when STACK_DEPTH entries are held: overwrites the oldest entry and sets stk_ovf.
- Pop when empty: returns stack entry 0 and sets stk_unf; depth stays 0.

Reset
REQ-031 SHALL, on reset, clear PC, MAR, IR, W, status, stack pointer/depth, stk_ovf and stk_unf, and set phase_q=T0, all at the next edge.
REQ-032 SHALL not clear RAM contents on reset.
REQ-033 SHALL, when reset is asserted in any state (including T4), make that edge perform no RAM write, W write or stack write.

Verification
REQ-034 SHALL pass: MOVLW 0x05; ADDLW 0xFB -> w_q=0x00, status_q={C=1,Z=1}; SUBLW 0x03 on W=0x05 -> w_q=0xFE, C=0.
REQ-035 SHALL pass: MOVLW 0x55; MOVWF 0x20; INCF 0x20,1; MOVF 0x20,0 -> w_q=0x56, Z=0.
REQ-036 SHALL pass: CALL 0x010 at address 0x003; RETURN at 0x010 -> rom_addr sequence 0x003, 0x010, 0x004; stack depth 0 afterwards.
REQ-037 SHALL pass: MOVLW 3; MOVWF 0x21; loop of DECFSZ 0x21,1 / GOTO loop -> loop body executes 3 times, then the GOTO at the exit is never presented on rom_addr and RAM[0x21]=0.
REQ-038 SHALL pass: 9 nested CALLs with STACK_DEPTH=8 -> stk_ovf=1; 9 RETURNs -> stk_unf=1 on the ninth pop.
REQ-039 SHALL pass: reset pulsed during T4 of ADDWF 0x22,1 -> RAM[0x22] unchanged, w_q=0, phase_q=0, then rom_addr=0x000 at the first T2.

Source files
------------

// File: rtl/pic_core_p.sv
// PIC-style 8-bit-class core with a 6-state instruction cycle.
// Harvard layout: external ROM, internal data RAM and circular return stack.
module pic_core_p #(
   parameter int DATA_W      = 8,
   parameter int PC_W        = 11,
   parameter int RAM_AW      = 7,
   parameter int STACK_DEPTH = 8
) (
   input  logic              clk,
   input  logic              reset,
   output logic [PC_W-1:0]   rom_addr,
   input  logic [13:0]       rom_data,
   output logic [DATA_W-1:0] w_q,
   output logic [1:0]        status_q,
   output logic              stk_ovf,
   output logic              stk_unf,
   output logic [2:0]        phase_q
);

   localparam int SP_W = $clog2(STACK_DEPTH);
   localparam logic [SP_W:0] FULL = (SP_W + 1)'(STACK_DEPTH);

   typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5, T6} phase_t;

   phase_t              phase;
   logic [PC_W-1:0]     pc;
   logic [13:0]         ir;
   logic                skip;
   logic [SP_W-1:0]     sp;
   logic [SP_W:0]       depth;
   logic [DATA_W-1:0]   ram [2**RAM_AW];
   logic [PC_W-1:0]     stack [STACK_DEPTH];

   logic [5:0]          op;
   logic                d;
   logic [RAM_AW-1:0]   fa;
   logic [DATA_W-1:0]   k;
   logic [DATA_W-1:0]   f;
   logic [DATA_W:0]     add_k;
   logic [DATA_W:0]     sub_k;
   logic [DATA_W:0]     add_f;
   logic [DATA_W:0]     sub_f;
   logic                bit_val;

   logic [DATA_W-1:0]   res;
   logic                wr_w;
   logic                wr_f;
   logic                upd_c;
   logic                c_new;
   logic                upd_z;
   logic                skip_set;
   logic                do_goto;
   logic                do_call;
   logic                do_ret;

   assign op       = ir[13:8];
   assign d        = ir[7];
   assign fa       = ir[RAM_AW-1:0];
   assign k        = DATA_W'(ir[7:0]);
   assign f        = ram[fa];
   assign add_k    = {1'b0, w_q} + {1'b0, k};
   assign sub_k    = {1'b0, k} - {1'b0, w_q};
   assign add_f    = {1'b0, f} + {1'b0, w_q};
   assign sub_f    = {1'b0, f} - {1'b0, w_q};
   assign bit_val  = |(f & (DATA_W'(1) << ir[9:7]));
   assign phase_q  = phase;

   // Instruction decode and ALU for the execute state
   always_comb begin
      res      = '0;
      wr_w     = 1'b0;
      wr_f     = 1'b0;
      upd_c    = 1'b0;
      c_new    = 1'b0;
      upd_z    = 1'b0;
      skip_set = 1'b0;
      do_goto  = 1'b0;
      do_call  = 1'b0;
      do_ret   = 1'b0;
      if (ir == 14'h0008) begin
         do_ret = 1'b1;
      end else begin
         casez (op)
            6'h30: begin res = k; wr_w = 1'b1; end
            6'h3E: begin
               res = add_k[DATA_W-1:0]; c_new = add_k[DATA_W];
               upd_c = 1'b1; upd_z = 1'b1; wr_w = 1'b1;
            end
            6'h3C: begin
               res = sub_k[DATA_W-1:0]; c_new = ~sub_k[DATA_W];
               upd_c = 1'b1; upd_z = 1'b1; wr_w = 1'b1;
            end
            6'h39: begin res = k & w_q; upd_z = 1'b1; wr_w = 1'b1; end
            6'h38: begin res = k | w_q; upd_z = 1'b1; wr_w = 1'b1; end
            6'h3A: begin res = k ^ w_q; upd_z = 1'b1; wr_w = 1'b1; end
            6'h07: begin
               res = add_f[DATA_W-1:0]; c_new = add_f[DATA_W];
               upd_c = 1'b1; upd_z = 1'b1; wr_w = ~d; wr_f = d;
            end
            6'h02: begin
               res = sub_f[DATA_W-1:0]; c_new = ~sub_f[DATA_W];
               upd_c = 1'b1; upd_z = 1'b1; wr_w = ~d; wr_f = d;
            end
            6'h05: begin res = f & w_q; upd_z = 1'b1; wr_w = ~d; wr_f = d; end
            6'h04: begin res = f | w_q; upd_z = 1'b1; wr_w = ~d; wr_f = d; end
            6'h06: begin res = f ^ w_q; upd_z = 1'b1; wr_w = ~d; wr_f = d; end
            6'h09: begin res = ~f; upd_z = 1'b1; wr_w = ~d; wr_f = d; end
            6'h0A: begin res = f + 1'b1; upd_z = 1'b1; wr_w = ~d; wr_f = d; end
            6'h03: begin res = f - 1'b1; upd_z = 1'b1; wr_w = ~d; wr_f = d; end
            6'h08: begin res = f; upd_z = 1'b1; wr_w = ~d; wr_f = d; end
            6'h0B: begin
               res = f - 1'b1; wr_w = ~d; wr_f = d;
               skip_set = (res == '0);
            end
            6'h0F: begin
               res = f + 1'b1; wr_w = ~d; wr_f = d;
               skip_set = (res == '0);
            end
            6'h01: begin res = '0; upd_z = 1'b1; wr_w = ~d; wr_f = d; end
            6'h00: begin res = w_q; wr_f = d; end
            6'b101???: do_goto = 1'b1;
            6'b100???: do_call = 1'b1;
            6'b0110??: skip_set = ~bit_val;
            6'b0111??: skip_set = bit_val;
            default: ;
         endcase
      end
   end

   // Phase sequencer with fetch, execute and skip handling
   always_ff @(posedge clk) begin
      if (reset) begin
         phase    <= T0;
         pc       <= '0;
         rom_addr <= '0;
         ir       <= '0;
         w_q      <= '0;
         status_q <= '0;
         skip     <= 1'b0;
         sp       <= '0;
         depth    <= '0;
         stk_ovf  <= 1'b0;
         stk_unf  <= 1'b0;
      end else begin
         case (phase)
            T0: phase <= T1;
            T1: begin rom_addr <= pc; phase <= T2; end
            T2: begin pc <= pc + 1'b1; phase <= T3; end
            T3: begin ir <= rom_data; phase <= T4; end
            T4: begin
               phase <= T5;
               skip  <= skip_set;
               if (wr_w) w_q <= res;
               if (upd_c) status_q[1] <= c_new;
               if (upd_z) status_q[0] <= (res == '0);
               if (do_goto) pc <= ir[PC_W-1:0];
               if (do_call) begin
                  pc <= ir[PC_W-1:0];
                  sp <= sp + 1'b1;
                  if (depth == FULL) stk_ovf <= 1'b1;
                  else depth <= depth + 1'b1;
               end
               if (do_ret) begin
                  if (depth == '0) begin
                     pc      <= stack[0];
                     stk_unf <= 1'b1;
                  end else begin
                     pc    <= stack[sp - 1'b1];
                     sp    <= sp - 1'b1;
                     depth <= depth - 1'b1;
                  end
               end
            end
            T5: begin
               if (skip) pc <= pc + 1'b1;
               skip  <= 1'b0;
               phase <= T6;
            end
            T6: phase <= T1;
            default: phase <= T0;
         endcase
      end
   end

   // Data RAM write port; contents survive reset
   always_ff @(posedge clk) begin
      if (!reset && phase == T4 && wr_f) ram[fa] <= res;
   end

   // Return stack write; a full stack overwrites its oldest slot
   always_ff @(posedge clk) begin
      if (!reset && phase == T4 && do_call) stack[sp] <= pc;
   end

endmodule

// File: tb/tb_pic_core_p.sv
// Directed self-checking bench for pic_core_p.
// Each program is loaded into a bench ROM and stepped instruction by instruction.
module tb_pic_core_p;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [10:0] rom_addr;
   logic [13:0] rom_data;
   logic [7:0]  w_q;
   logic [1:0]  status_q;
   logic        stk_ovf;
   logic        stk_unf;
   logic [2:0]  phase_q;

   logic [13:0] rom [2048];
   int checks = 0;
   int failures = 0;

   assign rom_data = rom[rom_addr];

   pic_core_p dut (
      .clk      (clk),
      .reset    (reset),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .w_q      (w_q),
      .status_q (status_q),
      .stk_ovf  (stk_ovf),
      .stk_unf  (stk_unf),
      .phase_q  (phase_q)
   );

   // Free-running clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_phase(input logic [2:0] p);
      int n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (phase_q !== p && n < 20);
      check("phase_wait", 32'(phase_q), 32'(p));
   endtask

   task automatic run_instr();
      wait_phase(3'd5);
   endtask

   task automatic exec(input string tag, input logic [7:0] w,
                       input logic [1:0] st);
      run_instr();
      check({tag, "_w"}, 32'(w_q), 32'(w));
      check({tag, "_st"}, 32'(status_q), 32'(st));
   endtask

   task automatic fetch(input string tag, input logic [10:0] a);
      wait_phase(3'd2);
      check(tag, 32'(rom_addr), 32'(a));
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 2048; i++) rom[i] = 14'h0000;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      clear_rom();
      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_phase", 32'(phase_q), 32'h0);
      check("rst_w", 32'(w_q), 32'h0);
      check("rst_st", 32'(status_q), 32'h0);
      check("rst_addr", 32'(rom_addr), 32'h0);
      check("rst_ovf", 32'(stk_ovf), 32'h0);
      check("rst_unf", 32'(stk_unf), 32'h0);

      // literal ALU ops
      rom[0] = 14'h3005; rom[1] = 14'h3EFB;
      rom[2] = 14'h3005; rom[3] = 14'h3C03;
      rom[4] = 14'h390F; rom[5] = 14'h3A0E;
      rom[6] = 14'h3880; rom[7] = 14'h0000;
      do_reset();
      exec("movlw5", 8'h05, 2'b00);
      exec("addlw", 8'h00, 2'b11);
      exec("movlw5b", 8'h05, 2'b11);
      exec("sublw", 8'hFE, 2'b00);
      exec("andlw", 8'h0E, 2'b00);
      exec("xorlw", 8'h00, 2'b01);
      exec("iorlw", 8'h80, 2'b00);
      exec("nop", 8'h80, 2'b00);

      // file ops and bit-test skips
      clear_rom();
      rom[0]  = 14'h3055; rom[1]  = 14'h00A0; rom[2]  = 14'h0AA0;
      rom[3]  = 14'h0820; rom[4]  = 14'h0920; rom[5]  = 14'h30FF;
      rom[6]  = 14'h0720; rom[7]  = 14'h0220; rom[8]  = 14'h1CA0;
      rom[9]  = 14'h3011; rom[10] = 14'h3022; rom[11] = 14'h1820;
      rom[12] = 14'h3033; rom[13] = 14'h3044; rom[14] = 14'h1920;
      rom[15] = 14'h3066; rom[16] = 14'h0100;
      do_reset();
      exec("movlw55", 8'h55, 2'b00);
      exec("movwf", 8'h55, 2'b00);
      exec("incf_f", 8'h55, 2'b00);
      exec("movf", 8'h56, 2'b00);
      exec("comf_w", 8'hA9, 2'b00);
      exec("movlwff", 8'hFF, 2'b00);
      exec("addwf", 8'h55, 2'b10);
      exec("subwf", 8'h01, 2'b10);
      exec("btfss", 8'h01, 2'b10);
      exec("after_btfss", 8'h22, 2'b10);
      exec("btfsc", 8'h22, 2'b10);
      exec("after_btfsc", 8'h44, 2'b10);
      exec("btfsc_ns", 8'h44, 2'b10);
      exec("after_ns", 8'h66, 2'b10);
      exec("clrw", 8'h00, 2'b11);

      // call / return and underflow
      clear_rom();
      rom[3] = 14'h2010; rom[16] = 14'h0008; rom[4] = 14'h0008;
      do_reset();
      fetch("call_a0", 11'h000);
      fetch("call_a1", 11'h001);
      fetch("call_a2", 11'h002);
      fetch("call_a3", 11'h003);
      fetch("call_a10", 11'h010);
      fetch("call_a4", 11'h004);
      check("call_unf0", 32'(stk_unf), 32'h0);
      run_instr();
      check("call_unf1", 32'(stk_unf), 32'h1);
      check("call_ovf", 32'(stk_ovf), 32'h0);
      fetch("unf_target", 11'h004);

      // decfsz loop
      clear_rom();
      rom[0] = 14'h3003; rom[1] = 14'h00A1; rom[2] = 14'h0BA1;
      rom[3] = 14'h2802; rom[4] = 14'h3077; rom[5] = 14'h0821;
      rom[6] = 14'h2806;
      do_reset();
      fetch("lp0", 11'd0);
      fetch("lp1", 11'd1);
      fetch("lp2", 11'd2);
      fetch("lp3", 11'd3);
      fetch("lp4", 11'd2);
      fetch("lp5", 11'd3);
      fetch("lp6", 11'd2);
      fetch("lp_exit", 11'd4);
      run_instr();
      check("lp_w77", 32'(w_q), 32'h77);
      fetch("lp8", 11'd5);
      run_instr();
      check("lp_ram", 32'(w_q), 32'h0);
      check("lp_z", 32'(status_q), 32'h1);
      fetch("lp9", 11'd6);

      // stack overflow and underflow
      clear_rom();
      for (int i = 0; i < 9; i++) begin
         rom[2*i]   = 14'h2000 | 14'(2*i + 2);
         rom[2*i+1] = 14'h0008;
      end
      rom[18] = 14'h0008;
      do_reset();
      for (int i = 0; i < 8; i++) run_instr();
      check("ovf_8calls", 32'(stk_ovf), 32'h0);
      run_instr();
      check("ovf_9calls", 32'(stk_ovf), 32'h1);
      for (int i = 0; i < 8; i++) run_instr();
      check("unf_8pops", 32'(stk_unf), 32'h0);
      fetch("pop8_addr", 11'd3);
      run_instr();
      check("unf_9pops", 32'(stk_unf), 32'h1);
      fetch("pop9_addr", 11'd17);

      // reset during execute
      clear_rom();
      rom[0] = 14'h3010; rom[1] = 14'h00A2;
      rom[2] = 14'h3005; rom[3] = 14'h07A2;
      do_reset();
      check("rst2_ovf", 32'(stk_ovf), 32'h0);
      check("rst2_unf", 32'(stk_unf), 32'h0);
      run_instr();
      run_instr();
      run_instr();
      wait_phase(3'd4);
      reset = 1'b1;
      rom[0] = 14'h0822;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("t4rst_w", 32'(w_q), 32'h0);
      check("t4rst_phase", 32'(phase_q), 32'h0);
      check("t4rst_st", 32'(status_q), 32'h0);
      fetch("t4rst_addr", 11'h000);
      run_instr();
      check("t4rst_ram", 32'(w_q), 32'h10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
